pipeline_fetch: RTL

//  Instruction-fetch stage: the producer side of the stage-0 decode interface (IR + PC).

---
 rtl/pipeline_fetch_pkg.sv | 33 +++
 rtl/pipeline_fetch_if.sv | 28 ++
 rtl/pipeline_fetch_fifo.sv | 52 +++++
 rtl/pipeline_fetch.sv | 98 +++++++++
 4 files changed

// File: rtl/pipeline_fetch_pkg.sv
// Shared ISA types for the fetch stage: widths, opcodes, fetch FSM states, FIFO entry.
// Pure declarations; no timing or backpressure of its own.
package kl_isa_pkg;

   localparam int PC_W = 8;
   localparam int IR_W = 16;

   typedef enum logic [2:0] {
      OP_NOP  = 3'b000,
      OP_LDR  = 3'b011,
      OP_STR  = 3'b100,
      OP_ALU  = 3'b101,
      OP_MOV  = 3'b110,
      OP_HALT = 3'b111
   } opcode_t;

   typedef enum logic [1:0] {
      ISSUE,
      WAIT_RSP,
      DROP,
      HALT
   } fetch_state_t;

   typedef struct packed {
      logic [IR_W-1:0] ir;
      logic [PC_W-1:0] pc;
   } fetch_entry_t;

   function automatic opcode_t get_opcode(input logic [IR_W-1:0] ir);
      return opcode_t'(ir[IR_W-1 -: 3]);
   endfunction

endpackage

// File: rtl/pipeline_fetch_if.sv
// Fetch-stage bundle: instruction-memory port, decode handshake, redirect and halt status.
// master = fetch stage, slave = memory/decode/redirect side.
interface pipeline_fetch_if;
   import kl_isa_pkg::*;

   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_valid;
   logic [IR_W-1:0] imem_rdata;
   logic            out_valid;
   logic            out_ready;
   logic [IR_W-1:0] IR_out;
   logic [PC_W-1:0] PC_out;
   logic            redirect_valid;
   logic [PC_W-1:0] redirect_pc;
   logic            halted;

   modport master (
      output imem_req, imem_addr, out_valid, IR_out, PC_out, halted,
      input  imem_valid, imem_rdata, out_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, out_valid, IR_out, PC_out, halted,
      output imem_valid, imem_rdata, out_ready, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/pipeline_fetch_fifo.sv
// Fetch buffer of DEPTH {IR,PC} entries with push/pop/flush and occupancy count.
// Push visible at head one cycle later (no bypass); pop ignored when empty; flush wins over both.
module fetch_fifo
   import kl_isa_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_push,
   input  fetch_entry_t i_push_dat,
   input  logic         i_pop,
   input  logic         i_flush,
   output fetch_entry_t o_head_dat,
   output logic         o_empty,
   output logic [AW:0]  o_count
);

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_pop;

   assign o_empty    = (r_count == '0);
   assign w_pop      = i_pop && !o_empty;
   assign o_head_dat = r_mem[r_rd_ptr];
   assign o_count    = r_count;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && !i_flush && i_push) r_mem[r_wr_ptr] <= i_push_dat;
   end

endmodule

// File: rtl/pipeline_fetch.sv
// Instruction fetch: single-outstanding imem reads into a BUF_DEPTH FIFO, redirects; HALT stop when FETCH_HALT_EN.
// Latency: request edge, response edge, entry visible to decode the cycle after (2 cycles with 1-cycle imem).
// Backpressure: head held while out_ready=0; no new request unless FIFO has room for the outstanding word.
module pipeline_fetch
   import kl_isa_pkg::*;
#(
   parameter int              BUF_DEPTH = 2,
   parameter logic [PC_W-1:0] RESET_PC  = 8'h00
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   pipeline_fetch_if.master bus
);

   localparam int               CNT_W   = $clog2(BUF_DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

   fetch_state_t     r_state;
   fetch_state_t     w_state_nxt;
   logic [PC_W-1:0]  r_pc;
   logic [PC_W-1:0]  r_req_pc;
   logic             w_req;
   logic             w_push;
   logic             w_empty;
   logic [CNT_W-1:0] w_count;
   fetch_entry_t     w_push_dat;
   fetch_entry_t     w_head;

   assign w_req      = i_rst_n && (r_state == ISSUE) && (w_count < DEPTH_C);
   assign w_push_dat = '{ir: bus.imem_rdata, pc: r_req_pc};

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      case (r_state)
         ISSUE:    if (w_req) w_state_nxt = WAIT_RSP;
         WAIT_RSP: begin
            if (bus.imem_valid) begin
               w_push      = 1'b1;
               w_state_nxt = ISSUE;
            end
         end
         DROP:     if (bus.imem_valid) w_state_nxt = ISSUE;
         default:  w_state_nxt = r_state;
      endcase
`ifdef FETCH_HALT_EN
      if (w_push && (get_opcode(bus.imem_rdata) == OP_HALT)) w_state_nxt = HALT;
`endif
      // A redirect discards any response landing now and turns an in-flight or
      // just-accepted request into a wrong-path fetch whose reply must be eaten.
      if (bus.redirect_valid) begin
         w_push = 1'b0;
         case (r_state)
            WAIT_RSP: w_state_nxt = bus.imem_valid ? ISSUE : DROP;
            DROP:     w_state_nxt = bus.imem_valid ? ISSUE : DROP;
            default:  w_state_nxt = w_req ? DROP : ISSUE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state  <= ISSUE;
         r_pc     <= RESET_PC;
         r_req_pc <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         if (bus.redirect_valid) r_pc <= bus.redirect_pc;
         else if (w_push)        r_pc <= r_pc + PC_W'(1);
         if (w_req) r_req_pc <= r_pc;
      end
   end

   fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_push     (w_push),
      .i_push_dat (w_push_dat),
      .i_pop      (bus.out_ready),
      .i_flush    (bus.redirect_valid),
      .o_head_dat (w_head),
      .o_empty    (w_empty),
      .o_count    (w_count)
   );

   assign bus.imem_req  = w_req;
   assign bus.imem_addr = r_pc;
   assign bus.out_valid = !w_empty;
   assign bus.IR_out    = w_empty ? '0 : w_head.ir;
   assign bus.PC_out    = w_empty ? '0 : w_head.pc;

`ifdef FETCH_HALT_EN
   assign bus.halted = (r_state == HALT);
`else
   assign bus.halted = 1'b0;
`endif

endmodule
